// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI4-Stream frame master.
package axis_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } axis_master_state_t;

  // Counter width for a modulus of n; a modulus of 1 still needs one bit.
  function automatic int cnt_width(input int n);
    cnt_width = (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer with registered in_ready and out_valid; order is
// preserved by always refilling the output register from the skid entry first.
module axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept_en,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  logic [WIDTH-1:0] out_data_r;
  logic [WIDTH-1:0] skid_data_r;
  logic             out_valid_r;
  logic             skid_valid_r;
  logic             in_ready_r;
  logic [WIDTH-1:0] out_data_next_s;
  logic [WIDTH-1:0] skid_data_next_s;
  logic             out_valid_next_s;
  logic             skid_valid_next_s;
  logic             push_s;
  logic             pop_s;

  // Next contents of both entries for the current push/pop combination.
  always_comb begin
    push_s            = in_valid && in_ready_r;
    pop_s             = out_valid_r && out_ready;
    out_data_next_s   = out_data_r;
    out_valid_next_s  = out_valid_r;
    skid_data_next_s  = skid_data_r;
    skid_valid_next_s = skid_valid_r;
    if (!out_valid_r || pop_s) begin
      if (skid_valid_r) begin
        out_data_next_s   = skid_data_r;
        out_valid_next_s  = 1'b1;
        skid_valid_next_s = 1'b0;
      end else if (push_s) begin
        out_data_next_s  = in_data;
        out_valid_next_s = 1'b1;
      end else begin
        out_valid_next_s = 1'b0;
      end
    end else if (push_s) begin
      skid_data_next_s  = in_data;
      skid_valid_next_s = 1'b1;
    end else begin
      skid_valid_next_s = skid_valid_r;
    end
  end

  // Entry registers; ready looks one cycle ahead so it never admits a third beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_r   <= {WIDTH{1'b0}};
      skid_data_r  <= {WIDTH{1'b0}};
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b0;
    end else begin
      out_data_r   <= out_data_next_s;
      skid_data_r  <= skid_data_next_s;
      out_valid_r  <= out_valid_next_s;
      skid_valid_r <= skid_valid_next_s;
      in_ready_r   <= accept_en && !skid_valid_next_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign occupancy = {1'b0, out_valid_r} + {1'b0, skid_valid_r};

endmodule

// File: rtl/axis_frame_master.sv
// AXI4-Stream video frame transmitter: tags producer pixels with start-of-frame
// and end-of-line and streams them out through a registered skid buffer.
module axis_frame_master
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int PIXELS_PER_LINE = 640,
  parameter int LINES_PER_FRAME = 480
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  busy,
  output logic                  frame_done
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
    logic                  user;
  } axis_beat_t;

  localparam int BEAT_W = $bits(axis_beat_t);
  localparam int PIX_W  = cnt_width(PIXELS_PER_LINE);
  localparam int LINE_W = cnt_width(LINES_PER_FRAME);
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(PIXELS_PER_LINE - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LINES_PER_FRAME - 1);

  axis_master_state_t state_r;
  axis_master_state_t state_next_s;
  logic [PIX_W-1:0]   pix_r;
  logic [LINE_W-1:0]  line_r;
  axis_beat_t         in_beat_s;
  axis_beat_t         out_beat_s;
  logic               out_valid_s;
  logic [1:0]         buf_occ_s;
  logic               in_accept_s;
  logic               out_accept_s;
  logic               accept_en_s;
  logic               busy_s;
  logic               done_s;
  logic               busy_r;
  logic               frame_done_r;

  assign in_accept_s  = in_valid && in_ready;
  assign out_accept_s = out_valid_s && m_axis_tready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state: the frame ends only once the last buffered beat leaves.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = start ? LOAD : IDLE;
      LOAD:    state_next_s = (in_accept_s && (pix_r == PIX_LAST) && (line_r == LINE_LAST)) ? DRAIN : LOAD;
      DRAIN:   state_next_s = (out_accept_s && (buf_occ_s == 2'd1)) ? IDLE : DRAIN;
      default: state_next_s = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered flags line up with it.
  always_comb begin
    accept_en_s = 1'b0;
    busy_s      = 1'b0;
    done_s      = 1'b0;
    case (state_next_s)
      IDLE:    done_s = (state_r == DRAIN);
      LOAD: begin
        accept_en_s = 1'b1;
        busy_s      = 1'b1;
      end
      DRAIN:   busy_s = 1'b1;
      default: busy_s = 1'b0;
    endcase
  end

  // Registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      busy_r       <= busy_s;
      frame_done_r <= done_s;
    end
  end

  // Pixel/line position of the next beat to be accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_r  <= {PIX_W{1'b0}};
      line_r <= {LINE_W{1'b0}};
    end else if ((state_r == IDLE) && start) begin
      pix_r  <= {PIX_W{1'b0}};
      line_r <= {LINE_W{1'b0}};
    end else if (in_accept_s) begin
      if (pix_r == PIX_LAST) begin
        pix_r  <= {PIX_W{1'b0}};
        line_r <= (line_r == LINE_LAST) ? {LINE_W{1'b0}} : line_r + LINE_W'(1);
      end else begin
        pix_r <= pix_r + PIX_W'(1);
      end
    end
  end

  // Tag the incoming pixel with its frame position.
  always_comb begin
    in_beat_s.data = in_data;
    in_beat_s.user = (line_r == {LINE_W{1'b0}}) && (pix_r == {PIX_W{1'b0}});
    in_beat_s.last = (pix_r == PIX_LAST);
  end

  axis_skid_buffer #(
    .WIDTH(BEAT_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .accept_en (accept_en_s),
    .in_data   (in_beat_s),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_beat_s),
    .out_valid (out_valid_s),
    .out_ready (m_axis_tready),
    .occupancy (buf_occ_s)
  );

  assign m_axis_tdata  = out_beat_s.data;
  assign m_axis_tlast  = out_beat_s.last;
  assign m_axis_tuser  = out_beat_s.user;
  assign m_axis_tvalid = out_valid_s;
  assign busy          = busy_r;
  assign frame_done    = frame_done_r;

endmodule

// File: doc/axis_frame_master.md
Name: axis_frame_master

Overview:
- AXI4-Stream master (transmitter) for video frames, one beat per pixel.
- Accepts pixels from an internal producer over a valid/ready port.
- Drives them onto m_axis_* with tuser marking start of frame (first beat) and tlast marking end of line (last beat of each line).
- Fully registered outputs through a 2-entry skid buffer; sustains 1 beat/cycle under continuous tready.

Parameters:
- DATA_WIDTH, 32, width of pixel/tdata.
- PIXELS_PER_LINE, 640, beats per line; must be >= 1.
- LINES_PER_FRAME, 480, lines per frame; must be >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle frame request; sampled only in IDLE.
- in_data  in  DATA_WIDTH  producer pixel.
- in_valid  in  1  producer valid.
- in_ready  out  1  block accepts in_data this cycle.
- m_axis_tdata  out  DATA_WIDTH  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  end of line.
- m_axis_tuser  out  1  start of frame.
- busy  out  1  frame in progress (state != IDLE).
- frame_done  out  1  one-cycle pulse after the final beat of the frame is accepted downstream.

Behaviour:
- Reset: every output is 0, both skid entries are empty, counters are 0, state is IDLE. Reset mid-frame aborts the frame; tvalid drops immediately and no frame_done is issued.
- Handshake rules:
  - Input beat accepted when in_valid && in_ready.
  - Output beat accepted when m_axis_tvalid && m_axis_tready.
  - Once tvalid is high, tvalid, tdata, tlast and tuser hold stable until accepted.
  - in_ready is a registered signal.
- State machine:
  - IDLE: in_ready=0. start=1 -> LOAD; pixel and line counters cleared.
  - LOAD: in_ready=1 while the skid buffer has a free entry. Each accepted input beat is tagged and pushed.
    - tuser = (line==0 && pix==0).
    - tlast = (pix==PIXELS_PER_LINE-1).
    - pix increments; it wraps to 0 at PIXELS_PER_LINE-1 and line increments.
    - Accepting beat pix=PPL-1, line=LPF-1 -> DRAIN, and in_ready is deasserted from the next cycle.
  - DRAIN: in_ready=0. When the skid buffer is empty and the final tagged beat has been accepted downstream -> IDLE with frame_done=1 for exactly one cycle.
  - start while not in IDLE is ignored.
- Latency: an input beat accepted in cycle N is presented on m_axis in cycle N+1 when the buffer was empty.
- Backpressure:
  - A second beat is held in the skid entry.
  - in_ready falls the cycle after the buffer becomes full.
  - No beat is lost or duplicated.
- Simultaneous push and pop with one entry occupied: occupancy stays 1 and order is preserved.
- Counter widths: $clog2 of the respective parameter, minimum 1 bit.
- PIXELS_PER_LINE=1: every beat has tlast=1.
- 1x1 frame: a single beat with tuser=1 and tlast=1.
- in_valid while in IDLE or DRAIN is ignored; the producer holds the beat.

Decomposition:
- Package axis_pkg:
  - state enum axis_master_state_t {IDLE, LOAD, DRAIN}.
  - packed struct axis_beat_t {data, last, user}, parameterised by DATA_WIDTH via localparam/typedef in the module.
- Sub-module axis_skid_buffer:
  - 2-entry, generic over payload width.
  - Registered in_ready and out_valid.
  - Reusable by other stream stages.
- The top holds the FSM, counters and tagging.

Test Plan:
- PPL=4, LPF=3, start, in_valid and tready held 1, data 0..11 -> 12 consecutive beats starting 1 cycle after the first accept. tuser only on beat 0; tlast on beats 3, 7, 11. frame_done pulses once, 1 cycle after beat 11 is accepted.
- Same frame with tready toggling 1,0,0,1 repeating -> tdata/tlast/tuser are stable while stalled. in_ready drops when 2 beats are buffered. The output sequence is identical to the first test.
- Producer gaps (in_valid 1,0,1,0...) with tready=1 -> tvalid has matching gaps, count is still 12, tags are correct, frame_done once.
- start pulsed again mid-frame and in_valid asserted while IDLE -> no effect. Exactly 12 beats; in_ready stays 0 in IDLE.
- Assert rst after beat 5 with tvalid high -> tvalid, busy and in_ready go 0 asynchronously with no frame_done. A following start sends a fresh 12-beat frame with tuser on its first beat.
- PPL=1, LPF=1 -> a single beat with tuser=1 and tlast=1, followed by frame_done.
